// File: rtl/intctl.sv
// Interrupt controller: latches five requests into IF, masks with IE, presents irq+vector; INTCTL_EDGE_EN selects edge-triggered sources.
// Latency: request to IF 1 cycle, IF to irq 1 cycle; no backpressure, ack is a one-cycle handshake from the CPU.
module intctl #(
    parameter logic [15:0] IF_ADDR = 16'hff0f,
    parameter logic [15:0] IE_ADDR = 16'hffff
) (
    input  logic        clockgb,
    input  logic        resetn,
    input  logic        intv,
    input  logic        intl,
    input  logic        intt,
    input  logic        ints,
    input  logic        intj,
    input  logic [15:0] address,
    input  logic [7:0]  indata,
    output logic [7:0]  outdata,
    input  logic        load,
    input  logic        store,
    output logic        irq,
    input  logic        ack,
    output logic [15:0] vector,
    output logic        wake,
    output logic [7:0]  dif
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state, state_nx;
    logic [4:0]  flags, flags_nx;
    logic [7:0]  ie;
    logic [4:0]  src, set, pend;
    logic [2:0]  num, num_nx, low;
    logic        irq_nx;
    logic [15:0] vector_nx;
    logic        wr_if, wr_ie;

    assign src   = {intj, ints, intt, intl, intv};
    assign wr_if = store && (address == IF_ADDR);
    assign wr_ie = store && (address == IE_ADDR);
    assign pend  = flags & ie[4:0];
    assign wake  = |pend;
    assign dif   = {3'b000, flags};

`ifdef INTCTL_EDGE_EN
    logic [4:0] src_q;

    always_ff @(posedge clockgb or negedge resetn) begin
        if (!resetn) src_q <= 5'd0;
        else         src_q <= src;
    end

    assign set = src & ~src_q;
`else
    assign set = src;
`endif

    // Write, then ack clear, then source set: a fresh request always survives.
    always_comb begin
        flags_nx = wr_if ? indata[4:0] : flags;
        if (state == REQ && ack) flags_nx[num] = 1'b0;
        flags_nx = flags_nx | set;
    end

    always_comb begin
        low = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (pend[i]) low = 3'(i);
        end
    end

    always_comb begin
        state_nx  = state;
        num_nx    = num;
        irq_nx    = irq;
        vector_nx = vector;
        case (state)
            IDLE: begin
                if (|pend) begin
                    state_nx  = REQ;
                    num_nx    = low;
                    irq_nx    = 1'b1;
                    vector_nx = 16'h0040 + {10'd0, low, 3'b000};
                end
            end
            REQ: begin
                // Vector stays locked to num; only ack or loss of the request ends REQ.
                if (ack) begin
                    state_nx = DONE;
                    irq_nx   = 1'b0;
                end else if (!flags[num] || !ie[num]) begin
                    state_nx = IDLE;
                    irq_nx   = 1'b0;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clockgb or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            flags  <= 5'd0;
            ie     <= 8'd0;
            num    <= 3'd0;
            irq    <= 1'b0;
            vector <= 16'd0;
        end else begin
            state  <= state_nx;
            flags  <= flags_nx;
            num    <= num_nx;
            irq    <= irq_nx;
            vector <= vector_nx;
            if (wr_ie) ie <= indata;
        end
    end

    always_comb begin
        outdata = 8'd0;
        if (resetn && load) begin
            if (address == IF_ADDR)      outdata = {3'b111, flags};
            else if (address == IE_ADDR) outdata = ie;
        end
    end

endmodule
